// File: rtl/memory_responder_if.sv
// Request/response bundle between the CPU request unit, the memory responder and the RAM model.
// The slave modport is the responder's view; the master modport is the requestor/RAM side.
interface memory_responder_if;
    // Instruction fetch port
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;

    // Data port
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic [31:0] dmemload;
    logic        dhit;

    // Single-ported RAM side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    // Sticky timeout indication
    logic        err;

    modport slave (
        input  imemREN, imemaddr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  ramload, ram_ready,
        output imemload, ihit,
        output dmemload, dhit,
        output ramREN, ramWEN, ramaddr, ramstore,
        output err
    );

    modport master (
        output imemREN, imemaddr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        output ramload, ram_ready,
        input  imemload, ihit,
        input  dmemload, dhit,
        input  ramREN, ramWEN, ramaddr, ramstore,
        input  err
    );
endinterface

// File: rtl/memory_responder.sv
// Memory responder: arbitrates instruction fetches and data reads/writes onto one RAM port,
// returns one-cycle ihit/dhit pulses with the load word, and force-completes stalled accesses
// after TIMEOUT cycles (returning ERR_WORD and setting a sticky err flag).
module memory_responder #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input logic                CLK,
    input logic                nRST,
    memory_responder_if.slave  bus
);

    // Grant FSM encoding
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StIacc = 2'd1;
    localparam logic [1:0] StDacc = 2'd2;
    localparam logic [1:0] StHold = 2'd3;

    // Last access cycle index before a stalled access is forced to complete
    localparam logic [7:0] TcntLast = 8'(TIMEOUT - 1);

    logic [1:0]  state_q,     state_d;
    logic        gnt_data_q,  gnt_data_d;
    logic        last_data_q, last_data_d;
    logic        req_wen_q,   req_wen_d;
    logic [31:0] addr_q,      addr_d;
    logic [31:0] store_q,     store_d;
    logic [7:0]  tcnt_q,      tcnt_d;
    logic [31:0] imemload_q,  imemload_d;
    logic [31:0] dmemload_q,  dmemload_d;
    logic        ihit_q,      ihit_d;
    logic        dhit_q,      dhit_d;
    logic        err_q,       err_d;

    // Combinational helpers for the arbitration and completion decisions
    logic        dreq;
    logic        grant_data;
    logic        in_acc;
    logic        timed_out;
    logic        acc_done;
    logic [31:0] load_word;

    // Next-state logic: grant in IDLE, wait for ram_ready or timeout in ACC, one HOLD cycle
    always_comb begin
        state_d     = state_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        req_wen_d   = req_wen_q;
        addr_d      = addr_q;
        store_d     = store_q;
        tcnt_d      = tcnt_q;
        imemload_d  = imemload_q;
        dmemload_d  = dmemload_q;
        ihit_d      = 1'b0;
        dhit_d      = 1'b0;
        err_d       = err_q;

        dreq       = bus.dmemREN | bus.dmemWEN;
        // On a tie the side not served last time wins; a lone request always wins
        grant_data = dreq & ~(bus.imemREN & last_data_q);
        in_acc     = (state_q == StIacc) || (state_q == StDacc);
        // ram_ready has priority over the timeout in the same cycle
        timed_out  = in_acc & ~bus.ram_ready & (tcnt_q == TcntLast);
        acc_done   = in_acc & (bus.ram_ready | timed_out);
        load_word  = bus.ram_ready ? bus.ramload : ERR_WORD;

        case (state_q)
            StIdle: begin
                if (dreq || bus.imemREN) begin
                    gnt_data_d  = grant_data;
                    last_data_d = grant_data;
                    req_wen_d   = bus.dmemWEN;
                    addr_d      = grant_data ? bus.dmemaddr : bus.imemaddr;
                    store_d     = bus.dmemstore;
                    tcnt_d      = 8'd0;
                    state_d     = grant_data ? StDacc : StIacc;
                end
            end

            StIacc, StDacc: begin
                if (acc_done) begin
                    if (gnt_data_q) begin
                        dhit_d = 1'b1;
                        // Writes complete without touching the data load register
                        if (!req_wen_q) begin
                            dmemload_d = load_word;
                        end
                    end else begin
                        ihit_d     = 1'b1;
                        imemload_d = load_word;
                    end
                    if (timed_out) begin
                        err_d = 1'b1;
                    end
                    state_d = StHold;
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end

            StHold: begin
                // Give the requestor one edge to drop its request before re-arbitrating
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset aborts any access in flight
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StIdle;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            req_wen_q   <= 1'b0;
            addr_q      <= 32'd0;
            store_q     <= 32'd0;
            tcnt_q      <= 8'd0;
            imemload_q  <= 32'd0;
            dmemload_q  <= 32'd0;
            ihit_q      <= 1'b0;
            dhit_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            req_wen_q   <= req_wen_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            tcnt_q      <= tcnt_d;
            imemload_q  <= imemload_d;
            dmemload_q  <= dmemload_d;
            ihit_q      <= ihit_d;
            dhit_q      <= dhit_d;
            err_q       <= err_d;
        end
    end

    // RAM strobes and bus come from registers only, gated to zero outside the ACC states
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = 32'd0;
        bus.ramstore = 32'd0;
        if (state_q == StIacc) begin
            bus.ramREN   = 1'b1;
            bus.ramaddr  = addr_q;
            bus.ramstore = store_q;
        end else if (state_q == StDacc) begin
            bus.ramREN   = ~req_wen_q;
            bus.ramWEN   = req_wen_q;
            bus.ramaddr  = addr_q;
            bus.ramstore = store_q;
        end
    end

    // Requestor-facing outputs
    always_comb begin
        bus.imemload = imemload_q;
        bus.dmemload = dmemload_q;
        bus.ihit     = ihit_q;
        bus.dhit     = dhit_q;
        bus.err      = err_q;
    end

    // Only one access is ever in flight, so the two hits are mutually exclusive
    a_hits_exclusive: assert property (@(posedge CLK) disable iff (!nRST) !(ihit_q && dhit_q));

    // A hit is only ever presented in the HOLD cycle
    a_hit_in_hold: assert property (@(posedge CLK) disable iff (!nRST)
        (ihit_q || dhit_q) |-> (state_q == StHold));

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: expected hits are queued when a request is
// driven and popped when ihit/dhit appears; a small RAM model answers after a set wait.
module tb_memory_responder;

    localparam logic [31:0] ErrWord = 32'hBAD1BAD1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    memory_responder_if bus();

    memory_responder #(
        .TIMEOUT  (16),
        .ERR_WORD (ErrWord)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_data;
        logic [31:0] load;
    } exp_t;

    exp_t        sb[$];
    int          vecs     = 0;
    int          miss     = 0;
    int          rdy_wait = 0;   // ACC-cycle index at which RAM answers; -1 = never
    int          acc_cyc  = 0;
    logic [31:0] exp_dload = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h2108000A;
        return {a[15:0] ^ 16'h1234, ~a[15:0]};
    endfunction

    // One cycle: advance to the falling edge, then play the RAM side for this cycle
    task automatic step();
        @(negedge CLK);
        if (bus.ramREN || bus.ramWEN) begin
            bus.ramload   = mem_word(bus.ramaddr);
            bus.ram_ready = (rdy_wait >= 0) && (acc_cyc == rdy_wait);
            acc_cyc++;
        end else begin
            bus.ramload   = 32'd0;
            bus.ram_ready = 1'b0;
            acc_cyc       = 0;
        end
    endtask

    // Step until a hit shows up; reports strobe counts and last RAM address/data seen
    task automatic run_until_hit(input int budget, input int chg_at,
                                 output int rc, output int wc,
                                 output logic [31:0] a_last, output logic [31:0] s_last,
                                 output bit hit);
        rc = 0; wc = 0; a_last = 32'd0; s_last = 32'd0; hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (bus.ramREN || bus.ramWEN) begin
                if (bus.ramREN) rc++;
                if (bus.ramWEN) wc++;
                a_last = bus.ramaddr;
                s_last = bus.ramstore;
                if (rc + wc - 1 == chg_at) begin
                    bus.dmemaddr  = 32'hFFFF_FFF0;
                    bus.dmemstore = 32'h0000_0000;
                    bus.imemaddr  = 32'hFFFF_0000;
                end
            end
            if (bus.ihit || bus.dhit) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e; int rc, wc; logic [31:0] a, s, gl; bit hit;
        bus.imemREN = 0; bus.imemaddr = 0; bus.dmemREN = 0; bus.dmemWEN = 0;
        bus.dmemaddr = 0; bus.dmemstore = 0; bus.ramload = 0; bus.ram_ready = 0;
        nRST = 1'b0;
        step(); step();
        vecs++;
        if ({bus.ihit, bus.dhit, bus.imemload, bus.dmemload, bus.ramREN, bus.ramWEN,
             bus.ramaddr, bus.ramstore, bus.err} !== '0) begin
            miss++; $display("FAIL reset_values: outputs not all zero in reset");
        end
        nRST = 1'b1;
        // Data read that never completes, then reset in the middle of DACC
        rdy_wait = -1; bus.dmemREN = 1; bus.dmemaddr = 32'h44;
        step(); step(); step();
        vecs++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44) begin
            miss++; $display("FAIL reset_pre_acc: ramREN=%b ramaddr=%h required 1/00000044",
                             bus.ramREN, bus.ramaddr);
        end
        #2 nRST = 1'b0;
        #1;
        vecs++;
        if ({bus.ihit, bus.dhit, bus.imemload, bus.dmemload, bus.ramREN, bus.ramWEN,
             bus.ramaddr, bus.ramstore, bus.err} !== '0) begin
            miss++; $display("FAIL reset_mid_dacc: ramREN=%b ramaddr=%h required 0/00000000",
                             bus.ramREN, bus.ramaddr);
        end
        bus.dmemREN = 0;
        step();
        nRST = 1'b1;
        // IDLE after release: a fetch gets its strobe in the very next cycle
        rdy_wait = 0; bus.imemREN = 1; bus.imemaddr = 32'h10;
        sb.push_back('{is_data: 1'b0, load: mem_word(32'h10)});
        step();
        vecs++;
        if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h10) begin
            miss++; $display("FAIL reset_idle_after: ramREN=%b ramaddr=%h required 1/00000010",
                             bus.ramREN, bus.ramaddr);
        end
        run_until_hit(10, -1, rc, wc, a, s, hit);
        vecs++;
        if (!hit || sb.size() == 0) begin
            miss++; $display("FAIL reset_fetch_hit: no hit, required ihit");
        end else begin
            e = sb.pop_front();
            gl = bus.dhit ? bus.dmemload : bus.imemload;
            if ({bus.dhit, bus.ihit, gl} !== {e.is_data, ~e.is_data, e.load}) begin
                miss++; $display("FAIL reset_fetch_hit: dhit/ihit/load=%b/%b/%h required %b/%b/%h",
                                 bus.dhit, bus.ihit, gl, e.is_data, ~e.is_data, e.load);
            end
        end
        bus.imemREN = 0;
        step();
    endtask

    task automatic test_simultaneous();
        exp_t e; int rc, wc; logic [31:0] a, s, gl; bit hit;
        // Fresh reset so the tie-break starts from last_data=0
        nRST = 1'b0; step(); nRST = 1'b1;
        rdy_wait = 0;
        bus.imemREN = 1; bus.imemaddr = 32'h200;
        bus.dmemREN = 1; bus.dmemaddr = 32'h300;
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{is_data: (k % 2 == 0), load: mem_word((k % 2 == 0) ? 32'h300 : 32'h200)});
        end
        for (int k = 0; k < 4; k++) begin
            run_until_hit(10, -1, rc, wc, a, s, hit);
            vecs++;
            if (!hit || sb.size() == 0) begin
                miss++; $display("FAIL simul_hit%0d: no hit within budget", k);
            end else begin
                e = sb.pop_front();
                gl = bus.dhit ? bus.dmemload : bus.imemload;
                if ({bus.dhit, bus.ihit, gl, rc} !== {e.is_data, ~e.is_data, e.load, 32'd1}) begin
                    miss++;
                    $display("FAIL simul_hit%0d: dhit/ihit/load/strobes=%b/%b/%h/%0d required %b/%b/%h/1",
                             k, bus.dhit, bus.ihit, gl, rc, e.is_data, ~e.is_data, e.load);
                end
            end
        end
        exp_dload = mem_word(32'h300);
        bus.imemREN = 0; bus.dmemREN = 0;
        step();
    endtask

    task automatic test_fetch();
        exp_t e; logic [31:0] gl;
        rdy_wait = 0; bus.imemREN = 1; bus.imemaddr = 32'h100;
        sb.push_back('{is_data: 1'b0, load: 32'h2108000A});
        step();
        vecs++;
        if ({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ihit} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
            miss++; $display("FAIL fetch_strobe: ren/wen/addr/ihit=%b/%b/%h/%b required 1/0/00000100/0",
                             bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ihit);
        end
        step();
        vecs++;
        if (sb.size() == 0) begin
            miss++; $display("FAIL fetch_hit: scoreboard empty");
        end else begin
            e = sb.pop_front();
            gl = bus.dhit ? bus.dmemload : bus.imemload;
            if ({bus.dhit, bus.ihit, gl, bus.ramREN} !== {e.is_data, ~e.is_data, e.load, 1'b0}) begin
                miss++; $display("FAIL fetch_hit: dhit/ihit/load/ren=%b/%b/%h/%b required %b/%b/%h/0",
                                 bus.dhit, bus.ihit, gl, bus.ramREN, e.is_data, ~e.is_data, e.load);
            end
        end
        bus.imemREN = 0;
        step();
        vecs++;
        if ({bus.ihit, bus.ramREN, bus.imemload} !== {1'b0, 1'b0, 32'h2108000A}) begin
            miss++; $display("FAIL fetch_after: ihit/ren/imemload=%b/%b/%h required 0/0/2108000a",
                             bus.ihit, bus.ramREN, bus.imemload);
        end
    endtask

    task automatic test_write();
        exp_t e; int rc, wc; logic [31:0] a, s, gl; bit hit;
        rdy_wait = 3; bus.dmemWEN = 1; bus.dmemaddr = 32'h80; bus.dmemstore = 32'hDEADBEEF;
        sb.push_back('{is_data: 1'b1, load: exp_dload});
        run_until_hit(20, -1, rc, wc, a, s, hit);
        vecs++;
        if (rc !== 0 || wc !== 4 || a !== 32'h80 || s !== 32'hDEADBEEF) begin
            miss++; $display("FAIL write_strobes: ren/wen cycles=%0d/%0d addr=%h store=%h required 0/4 00000080 deadbeef",
                             rc, wc, a, s);
        end
        vecs++;
        if (!hit || sb.size() == 0) begin
            miss++; $display("FAIL write_hit: no hit within budget");
        end else begin
            e = sb.pop_front();
            gl = bus.dhit ? bus.dmemload : bus.imemload;
            if ({bus.dhit, bus.ihit, gl} !== {e.is_data, ~e.is_data, e.load}) begin
                miss++; $display("FAIL write_hit: dhit/ihit/load=%b/%b/%h required %b/%b/%h",
                                 bus.dhit, bus.ihit, gl, e.is_data, ~e.is_data, e.load);
            end
        end
        bus.dmemWEN = 0;
        step();
        vecs++;
        if ({bus.dhit, bus.ramWEN} !== 2'b00) begin
            miss++; $display("FAIL write_after: dhit/wen=%b/%b required 0/0", bus.dhit, bus.ramWEN);
        end
    endtask

    task automatic test_collision();
        exp_t e; int rc, wc; logic [31:0] a, s, gl; bit hit;
        // RAM answers on the 16th ACC cycle, the same cycle the timeout would fire
        rdy_wait = 15; bus.dmemREN = 1; bus.dmemaddr = 32'h600;
        sb.push_back('{is_data: 1'b1, load: mem_word(32'h600)});
        run_until_hit(40, 2, rc, wc, a, s, hit);
        vecs++;
        if (rc !== 16 || a !== 32'h600) begin
            miss++; $display("FAIL collide_strobes: ren cycles=%0d addr=%h required 16 00000600", rc, a);
        end
        vecs++;
        if (!hit || sb.size() == 0) begin
            miss++; $display("FAIL collide_hit: no hit within budget");
        end else begin
            e = sb.pop_front();
            gl = bus.dhit ? bus.dmemload : bus.imemload;
            if ({bus.dhit, bus.ihit, gl, bus.err} !== {e.is_data, ~e.is_data, e.load, 1'b0}) begin
                miss++; $display("FAIL collide_hit: dhit/ihit/load/err=%b/%b/%h/%b required %b/%b/%h/0",
                                 bus.dhit, bus.ihit, gl, bus.err, e.is_data, ~e.is_data, e.load);
            end
        end
        exp_dload = mem_word(32'h600);
        bus.dmemREN = 0; bus.dmemaddr = 32'h0;
        step();
    endtask

    task automatic test_timeout();
        exp_t e; int rc, wc; logic [31:0] a, s, gl; bit hit;
        rdy_wait = -1; bus.dmemREN = 1; bus.dmemaddr = 32'h40;
        sb.push_back('{is_data: 1'b1, load: ErrWord});
        run_until_hit(40, -1, rc, wc, a, s, hit);
        vecs++;
        if (rc !== 16) begin
            miss++; $display("FAIL timeout_strobes: ren cycles=%0d required 16", rc);
        end
        vecs++;
        if (!hit || sb.size() == 0) begin
            miss++; $display("FAIL timeout_hit: no hit within budget");
        end else begin
            e = sb.pop_front();
            gl = bus.dhit ? bus.dmemload : bus.imemload;
            if ({bus.dhit, bus.ihit, gl, bus.err} !== {e.is_data, ~e.is_data, e.load, 1'b1}) begin
                miss++; $display("FAIL timeout_hit: dhit/ihit/load/err=%b/%b/%h/%b required %b/%b/%h/1",
                                 bus.dhit, bus.ihit, gl, bus.err, e.is_data, ~e.is_data, e.load);
            end
        end
        exp_dload = ErrWord;
        bus.dmemREN = 0;
        step();
        // A later good fetch returns real data while err stays set
        rdy_wait = 1; bus.imemREN = 1; bus.imemaddr = 32'h500;
        sb.push_back('{is_data: 1'b0, load: mem_word(32'h500)});
        run_until_hit(20, -1, rc, wc, a, s, hit);
        vecs++;
        if (!hit || sb.size() == 0) begin
            miss++; $display("FAIL sticky_err_hit: no hit within budget");
        end else begin
            e = sb.pop_front();
            gl = bus.dhit ? bus.dmemload : bus.imemload;
            if ({bus.dhit, bus.ihit, gl, bus.err, rc} !== {e.is_data, ~e.is_data, e.load, 1'b1, 32'd2}) begin
                miss++; $display("FAIL sticky_err_hit: dhit/ihit/load/err/strobes=%b/%b/%h/%b/%0d required %b/%b/%h/1/2",
                                 bus.dhit, bus.ihit, gl, bus.err, rc, e.is_data, ~e.is_data, e.load);
            end
        end
        bus.imemREN = 0;
        step();
        vecs++;
        if ({bus.err, bus.dmemload} !== {1'b1, exp_dload}) begin
            miss++; $display("FAIL sticky_err_end: err/dmemload=%b/%h required 1/%h",
                             bus.err, bus.dmemload, exp_dload);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_fetch();
        test_write();
        test_collision();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vecs, miss);
        $fatal(1, "watchdog expired");
    end

endmodule
